// File: rtl/arb_grant_mux.sv
// arb_grant_mux
//   Packet-locking data path behind a round-robin arbiter. While idle it
//   forwards per-port valids to the arbiter as requests. On a legal one-hot
//   grant to a port that is still valid, it locks onto that port and steers
//   its beats through a registered valid/ready output stage. It releases on
//   the last beat, or forces a last beat after MAX_BEATS beats.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid_i   per-port beat valid
//   in_data_i    per-port beat data, port p at [p*DATA_W +: DATA_W]
//   in_last_i    per-port last-beat flag
//   in_ready_o   per-port beat accept (only the owner, only while locked)
//   arb_req_o    request vector to the arbiter (idle only)
//   arb_gnt_i    one-hot grant from the arbiter
//   out_valid_o  registered shared-channel valid
//   out_data_o   registered shared-channel data
//   out_last_o   registered shared-channel last flag
//   out_port_o   registered source port of the current beat
//   out_ready_i  downstream accept
//   err_o        sticky errors: [0] illegal multi-hot grant, [1] packet overrun
//
// state  | meaning
// IDLE   | requests forwarded to arbiter, waiting for a usable grant
// LOCKED | owner port's packet streams to the output register

module arb_grant_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        in_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
  input  logic [NUM_PORTS-1:0]        in_last_i,
  output logic [NUM_PORTS-1:0]        in_ready_o,
  output logic [NUM_PORTS-1:0]        arb_req_o,
  input  logic [NUM_PORTS-1:0]        arb_gnt_i,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_last_o,
  output logic [PW-1:0]               out_port_o,
  input  logic                        out_ready_i,
  output logic [1:0]                  err_o
);

  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       owner, owner_nxt;
  logic [CW-1:0]       beat_cnt, cnt_nxt;

  logic                gnt_onehot;
  logic                gnt_multi;
  logic [PW-1:0]       gnt_idx;

  logic [NUM_PORTS-1:0] owner_mask;
  logic                own_valid;
  logic                own_last;
  logic [DATA_W-1:0]   own_data;

  logic                out_room;
  logic                at_max;
  logic                xfer;
  logic                set_illegal;
  logic                set_overrun;

  // Grant decode. gnt_idx is only meaningful when the grant is one-hot.
  always_comb begin
    gnt_onehot = $onehot(arb_gnt_i);
    gnt_multi  = (|arb_gnt_i) && !gnt_onehot;
    gnt_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_gnt_i[i]) gnt_idx = PW'(i);
    end
  end

  // Owner-port selection of the input bundle.
  always_comb begin
    owner_mask = '0;
    own_data   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == PW'(i)) begin
        owner_mask[i] = 1'b1;
        own_data      = in_data_i[i*DATA_W +: DATA_W];
      end
    end
    own_valid = |(in_valid_i & owner_mask);
    own_last  = |(in_last_i & owner_mask);
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign out_room = !out_valid_o || out_ready_i;
  assign at_max   = (beat_cnt == LAST_CNT);

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    cnt_nxt     = beat_cnt;
    arb_req_o   = '0;
    in_ready_o  = '0;
    xfer        = 1'b0;
    set_illegal = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        arb_req_o = in_valid_i;
        // A one-hot grant to a port that dropped valid is simply ignored.
        if (gnt_onehot && |(arb_gnt_i & in_valid_i)) begin
          owner_nxt = gnt_idx;
          cnt_nxt   = '0;
          state_nxt = LOCKED;
        end else if (gnt_multi) begin
          set_illegal = 1'b1;
        end
      end
      LOCKED: begin
        if (out_room) in_ready_o = owner_mask;
        xfer = own_valid && out_room;
        if (xfer) begin
          cnt_nxt = beat_cnt + 1'b1;
          if (own_last || at_max) state_nxt = IDLE;
          set_overrun = at_max && !own_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      err_o    <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
      err_o    <= err_o | {set_overrun, set_illegal};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_port_o  <= '0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= own_data;
      out_last_o  <= own_last || at_max;
      out_port_o  <= owner;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
